ads1115_scan_sequencer: RTL and testbench
=========================================

# ads1115_scan_sequencer

Parametrised command sequencer for the ADS1115 ADC. Generates I2C transaction descriptors for a byte-level I2C engine over a valid/ready handshake. Scans 1–4 single-ended channels in single-shot mode, polling the OS bit rather than relying on a fixed delay. Returns one 16-bit sample per channel, tagged with its channel number, to downstream logic (display/UI).

## Interface
- `NUM_CH`, 4: channels scanned, AIN0..AIN(NUM_CH-1); legal 1–4.
- `I2C_ADDR`, 7'h48: 7-bit device address.
- `PGA`, 3'b001: config PGA field (±4.096 V).
- `DR`, 3'b100: config data-rate field (128 SPS).
- `CONV_WAIT`, 16'd50000: clk cycles between config write and first poll.
- `POLL_MAX`, 8'd16: maximum OS polls before timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: start/continue scanning.
- `continuous` in 1: wrap to channel 0 after the last channel; sampled at the end of each scan.
- `cmd_valid` out 1: descriptor valid.
- `cmd_ready` in 1: engine accepts descriptor.
- `cmd_kind` out 2: 0 = WRITE2 (ptr+2 bytes), 1 = PTR_ONLY, 2 = READ2.
- `cmd_addr` out 7: device address.
- `cmd_reg` out 8: pointer byte.
- `cmd_data` out 16: write payload, MSB first.
- `rsp_valid` in 1: transaction finished (one-cycle pulse).
- `rsp_nack` in 1: NACK seen; qualified by `rsp_valid`.
- `rsp_data` in 16: read data; qualified by `rsp_valid`.
- `sample_valid` out 1: one-cycle pulse.
- `sample_ch` out 2: channel of the sample.
- `sample_data` out 16: conversion result, two's complement.
- `busy` out 1: FSM not in IDLE.
- `err_nack` out 1: sticky; cleared on the next scan start.
- `err_timeout` out 1: sticky; cleared on the next scan start.

## Operation
- States: IDLE, CFG_WR, CONV_WAIT, PTR_CFG, RD_CFG, PTR_CONV, RD_CONV, EMIT.
- IDLE → CFG_WR when `enable`=1. Entering from IDLE clears `ch` to 0 and clears both error flags.
- **CFG_WR**: WRITE2, reg 8'h01.
  - data = {1, 1, ch[1:0], PGA, 1, DR, 5'b00011}.
  - Example: ch0 with defaults = 16'hC383.
- **CONV_WAIT**: counts CONV_WAIT cycles, then → PTR_CFG with the poll counter cleared.
- **PTR_CFG**: PTR_ONLY, reg 8'h01; → RD_CFG.
- **RD_CFG**: READ2.
  - If `rsp_data[15]`=1 → PTR_CONV.
  - Otherwise increment the poll count. At POLL_MAX → set `err_timeout`, go to IDLE. Else → PTR_CFG.
- **PTR_CONV**: PTR_ONLY, reg 8'h00; then **RD_CONV**: READ2, capture `rsp_data`.
- **EMIT**: pulse `sample_valid` with `ch` and the data.
  - If `ch` < NUM_CH-1: `ch`++, → CFG_WR.
  - Else if `continuous` && `enable`: `ch`=0, → CFG_WR.
  - Else → IDLE.
- **enable deassert mid-scan**: the current channel runs to EMIT, then → IDLE. No descriptor is ever abandoned.
- **NACK**: any `rsp_valid` with `rsp_nack`=1 sets `err_nack` and → IDLE. `sample_valid` is not pulsed.
- **Reset** (any time, including mid-transaction): all state and outputs return to reset values immediately. An engine response arriving after reset is ignored in IDLE.

## Timing
- Reset values:
  - `cmd_valid`=0, `cmd_kind`=0, `cmd_addr`=I2C_ADDR, `cmd_reg`=0, `cmd_data`=0.
  - `sample_valid`=0, `sample_ch`=0, `sample_data`=0, `busy`=0, both error flags 0.
  - FSM=IDLE.
- All outputs are registered.
- `cmd_valid` rises the cycle after entering a command state.
- `cmd_*` fields hold stable while `cmd_valid && !cmd_ready`. `cmd_valid` drops the cycle after the handshake.
- After the handshake the FSM waits for `rsp_valid`. `rsp_valid` arriving in the same cycle as the handshake is not legal from the engine.
- `rsp_valid` with `cmd_valid`=1 still pending is ignored.
- `sample_valid` asserts exactly one cycle after the RD_CONV `rsp_valid`.
- CONV_WAIT lasts exactly CONV_WAIT cycles; a value of 0 means no wait.
- `busy` is high from the cycle after `enable` is sampled in IDLE until the cycle after returning to IDLE.

## Structure
- Package `ads1115_pkg`:
  - Pointer constants CONV=8'h00, CONFIG=8'h01, LO_THRESH=8'h02, HI_THRESH=8'h03.
  - `cmd_kind` encoding.
  - FSM state enum.
  - Config-word field positions.
- Sub-module `ads1115_cfg_word`: combinational builder of the 16-bit config from `ch`, PGA and DR. It is kept separate so a future comparator/threshold mode can reuse it.
- The wait counter and poll counter live in the top module.

## Test plan
- **Single scan**: NUM_CH=2, continuous=0, enable pulse, engine model always ready and ACKs.
  - Descriptors: WRITE2 01/C383, PTR 01, READ2, PTR 00, READ2, then WRITE2 01/D383, and so on.
  - Two samples, ch0 then ch1; then `busy`=0.
- **OS polling**: `rsp_data` = 16'h4383 twice, then 16'hC383.
  - Exactly 3 RD_CFG reads; conversion read 16'h1234 → `sample_data`=16'h1234.
- **Timeout**: POLL_MAX=4, OS never set.
  - 4 polls, then `err_timeout`=1, FSM=IDLE, no `sample_valid`.
- **NACK**: `rsp_nack`=1 on CFG_WR.
  - `err_nack`=1, FSM=IDLE. The next enable clears the flag and restarts at ch0.
- **Continuous wrap and stall**: NUM_CH=4, continuous=1, `cmd_ready` held low 5 cycles.
  - `cmd_*` stable during the stall. Samples ch0..3 then ch0 again.
  - Deasserting enable during ch1 yields ch1's sample, then IDLE.
- **Async reset**: `rst_n` low mid-RD_CONV with `cmd_valid`=1.
  - All outputs at reset values within the same cycle; a late `rsp_valid` causes no sample.

Source files
------------

// File: rtl/ads1115_pkg.sv
// Shared constants, encodings and payload types for the ADS1115 scan sequencer.
package ads1115_pkg;

    // ADS1115 pointer register addresses
    localparam logic [7:0] REG_CONV      = 8'h00;
    localparam logic [7:0] REG_CONFIG    = 8'h01;
    localparam logic [7:0] REG_LO_THRESH = 8'h02;
    localparam logic [7:0] REG_HI_THRESH = 8'h03;

    // Descriptor kinds understood by the byte-level I2C engine
    typedef enum logic [1:0] {
        KIND_WRITE2   = 2'd0,
        KIND_PTR_ONLY = 2'd1,
        KIND_READ2    = 2'd2
    } cmd_kind_e;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_WR,
        ST_CONV_WAIT,
        ST_PTR_CFG,
        ST_RD_CFG,
        ST_PTR_CONV,
        ST_RD_CONV,
        ST_EMIT
    } state_e;

    // Config register field positions
    localparam int unsigned CFG_W        = 16;
    localparam int unsigned CFG_OS_BIT   = 15;
    localparam int unsigned CFG_MUX_LSB  = 12;
    localparam int unsigned CFG_PGA_LSB  = 9;
    localparam int unsigned CFG_MODE_BIT = 8;
    localparam int unsigned CFG_DR_LSB   = 5;
    localparam int unsigned CFG_COMP_LSB = 0;

    // Comparator disabled, ALERT/RDY high-impedance
    localparam logic [4:0] CFG_COMP_DISABLE = 5'b00011;

    // Descriptor payload presented to the I2C engine (address carried separately)
    typedef struct packed {
        cmd_kind_e   kind;
        logic [7:0]  ptr;
        logic [15:0] data;
    } cmd_desc_t;

endpackage

// File: rtl/ads1115_cfg_word.sv
// Combinational builder of the single-shot, single-ended ADS1115 config word.
module ads1115_cfg_word
    import ads1115_pkg::*;
(
    input  logic [1:0]       ch_i,
    input  logic [2:0]       pga_i,
    input  logic [2:0]       dr_i,
    output logic [CFG_W-1:0] cfg_c
);

    // Start conversion (OS=1), MUX=1xx selects AINx vs GND, single-shot mode
    always_comb begin
        cfg_c                       = '0;
        cfg_c[CFG_OS_BIT]           = 1'b1;
        cfg_c[CFG_MUX_LSB +: 3]     = {1'b1, ch_i};
        cfg_c[CFG_PGA_LSB +: 3]     = pga_i;
        cfg_c[CFG_MODE_BIT]         = 1'b1;
        cfg_c[CFG_DR_LSB +: 3]      = dr_i;
        cfg_c[CFG_COMP_LSB +: 5]    = CFG_COMP_DISABLE;
    end

endmodule

// File: rtl/ads1115_scan_sequencer.sv
// Scans ADS1115 channels in single-shot mode, polling OS, and emits tagged samples.
module ads1115_scan_sequencer
    import ads1115_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [6:0]  I2C_ADDR  = 7'h48,
    parameter logic [2:0]  PGA       = 3'b001,
    parameter logic [2:0]  DR        = 3'b100,
    parameter logic [15:0] CONV_WAIT = 16'd50000,
    parameter logic [7:0]  POLL_MAX  = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        continuous,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_kind,
    output logic [6:0]  cmd_addr,
    output logic [7:0]  cmd_reg,
    output logic [15:0] cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [15:0] rsp_data,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [15:0] sample_data,
    output logic        busy,
    output logic        err_nack,
    output logic        err_timeout
);

    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    state_e      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] wait_q, wait_d;
    logic [7:0]  poll_q, poll_d;
    logic        rsp_pend_q, rsp_pend_d;
    logic        cmd_valid_q, cmd_valid_d;
    cmd_desc_t   cmd_q, cmd_d;
    logic [6:0]  cmd_addr_q;
    logic        sample_valid_q, sample_valid_d;
    logic [1:0]  sample_ch_q, sample_ch_d;
    logic [15:0] sample_data_q, sample_data_d;
    logic        busy_q, busy_d;
    logic        err_nack_q, err_nack_d;
    logic        err_timeout_q, err_timeout_d;

    logic [15:0] cfg_word_c;
    cmd_desc_t   desc_c;
    logic [7:0]  poll_inc_c;

    ads1115_cfg_word u_cfg_word (
        .ch_i  (ch_q),
        .pga_i (PGA),
        .dr_i  (DR),
        .cfg_c (cfg_word_c)
    );

    // Descriptor that the current command state issues
    always_comb begin
        desc_c = '{kind: KIND_WRITE2, ptr: REG_CONFIG, data: cfg_word_c};
        case (state_q)
            ST_PTR_CFG:  desc_c = '{kind: KIND_PTR_ONLY, ptr: REG_CONFIG, data: 16'h0000};
            ST_RD_CFG:   desc_c = '{kind: KIND_READ2,    ptr: REG_CONFIG, data: 16'h0000};
            ST_PTR_CONV: desc_c = '{kind: KIND_PTR_ONLY, ptr: REG_CONV,   data: 16'h0000};
            ST_RD_CONV:  desc_c = '{kind: KIND_READ2,    ptr: REG_CONV,   data: 16'h0000};
            default:     ;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        wait_d         = wait_q;
        poll_d         = poll_q;
        rsp_pend_d     = rsp_pend_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_d          = cmd_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        err_nack_d     = err_nack_q;
        err_timeout_d  = err_timeout_q;
        poll_inc_c     = poll_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d       = ST_CFG_WR;
                    ch_d          = '0;
                    err_nack_d    = 1'b0;
                    err_timeout_d = 1'b0;
                end
            end

            ST_CONV_WAIT: begin
                if (wait_q == CONV_WAIT - 16'd1) begin
                    state_d = ST_PTR_CFG;
                    poll_d  = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            // Enable low finishes the current channel only; otherwise step or wrap
            ST_EMIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ch_q != LAST_CH) begin
                    ch_d    = ch_q + 2'd1;
                    state_d = ST_CFG_WR;
                end else if (continuous) begin
                    ch_d    = '0;
                    state_d = ST_CFG_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Command states: present descriptor, handshake, then await response
            default: begin
                if (!cmd_valid_q && !rsp_pend_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = desc_c;
                end else if (cmd_valid_q) begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        rsp_pend_d  = 1'b1;
                    end
                end else if (rsp_valid) begin
                    rsp_pend_d = 1'b0;
                    if (rsp_nack) begin
                        err_nack_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_CFG_WR: begin
                                if (CONV_WAIT == 16'd0) begin
                                    state_d = ST_PTR_CFG;
                                    poll_d  = '0;
                                end else begin
                                    state_d = ST_CONV_WAIT;
                                    wait_d  = '0;
                                end
                            end
                            ST_PTR_CFG: state_d = ST_RD_CFG;
                            ST_RD_CFG: begin
                                if (rsp_data[CFG_OS_BIT]) begin
                                    state_d = ST_PTR_CONV;
                                end else begin
                                    poll_d = poll_inc_c;
                                    if (poll_inc_c == POLL_MAX) begin
                                        err_timeout_d = 1'b1;
                                        state_d       = ST_IDLE;
                                    end else begin
                                        state_d = ST_PTR_CFG;
                                    end
                                end
                            end
                            ST_PTR_CONV: state_d = ST_RD_CONV;
                            ST_RD_CONV: begin
                                sample_valid_d = 1'b1;
                                sample_ch_d    = ch_q;
                                sample_data_d  = rsp_data;
                                state_d        = ST_EMIT;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            wait_q         <= '0;
            poll_q         <= '0;
            rsp_pend_q     <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_q          <= '{kind: KIND_WRITE2, ptr: 8'h00, data: 16'h0000};
            cmd_addr_q     <= I2C_ADDR;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            busy_q         <= 1'b0;
            err_nack_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            wait_q         <= wait_d;
            poll_q         <= poll_d;
            rsp_pend_q     <= rsp_pend_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_q          <= cmd_d;
            cmd_addr_q     <= I2C_ADDR;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            busy_q         <= busy_d;
            err_nack_q     <= err_nack_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_kind     = cmd_q.kind;
    assign cmd_addr     = cmd_addr_q;
    assign cmd_reg      = cmd_q.ptr;
    assign cmd_data     = cmd_q.data;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign busy         = busy_q;
    assign err_nack     = err_nack_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_ads1115_scan_sequencer.sv
// Directed bench for ads1115_scan_sequencer with an I2C engine model and sample scoreboard.
module tb_ads1115_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        continuous = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_kind;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic        rsp_valid = 1'b0;
    logic        rsp_nack = 1'b0;
    logic [15:0] rsp_data = 16'h0000;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [15:0] sample_data;
    logic        busy;
    logic        err_nack;
    logic        err_timeout;

    always #5 clk = ~clk;

    ads1115_scan_sequencer #(
        .NUM_CH    (4),
        .I2C_ADDR  (7'h48),
        .PGA       (3'b001),
        .DR        (3'b100),
        .CONV_WAIT (16'd3),
        .POLL_MAX  (8'd4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .continuous   (continuous),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_kind     (cmd_kind),
        .cmd_addr     (cmd_addr),
        .cmd_reg      (cmd_reg),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_nack     (rsp_nack),
        .rsp_data     (rsp_data),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .busy         (busy),
        .err_nack     (err_nack),
        .err_timeout  (err_timeout)
    );

    // Scoreboards: expected descriptors {kind,reg,data}, expected samples {ch,data}
    logic [25:0] exp_desc[$];
    logic [17:0] exp_samp[$];
    logic [15:0] os_q[$];
    logic [15:0] conv_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Engine-model knobs and state
    bit          chk_desc   = 1'b0;
    bit          nack_next  = 1'b0;
    bit          hold_conv  = 1'b0;
    bit          inject_rsp = 1'b0;
    bit          sample_due = 1'b0;
    bit          stall_cap  = 1'b0;
    int          stall_left = 0;
    int          rsp_wait   = 0;
    int          n_samples  = 0;
    int          n_desc     = 0;
    int          n_cfg_reads = 0;
    int          stall_cmp  = 0;
    logic [1:0]  pend_kind  = 2'd0;
    logic [7:0]  pend_reg   = 8'h00;
    logic [32:0] cap        = '0;
    logic [25:0] ed;
    logic [17:0] es;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cfg(input int ch);
        return 16'hC383 | (16'(ch) << 12);
    endfunction

    task automatic push_channel_descs(input int ch);
        exp_desc.push_back({2'd0, 8'h01, exp_cfg(ch)});
        exp_desc.push_back({2'd1, 8'h01, 16'h0000});
        exp_desc.push_back({2'd2, 8'h01, 16'h0000});
        exp_desc.push_back({2'd1, 8'h00, 16'h0000});
        exp_desc.push_back({2'd2, 8'h00, 16'h0000});
    endtask

    task automatic push_sample(input int ch, input logic [15:0] v);
        conv_q.push_back(v);
        exp_samp.push_back({2'(ch), v});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_busy(input logic val, input int budget, input string tag);
        int n = 0;
        while (busy !== val && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 64'(busy), 64'(val));
    endtask

    task automatic wait_samples(input int target, input int budget, input string tag);
        int n = 0;
        while (n_samples < target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 64'(n_samples >= target), 64'd1);
    endtask

    // I2C engine model and sample monitor, all on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (sample_due) begin
                check("sample_latency", 64'(sample_valid), 64'd1);
                sample_due = 1'b0;
            end
            if (sample_valid === 1'b1) begin
                n_samples++;
                es = (exp_samp.size() > 0) ? exp_samp.pop_front() : 18'h3FFFF;
                check("sample", 64'({sample_ch, sample_data}), 64'(es));
            end

            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            rsp_data  = 16'h0000;
            if (inject_rsp) begin
                rsp_valid  = 1'b1;
                rsp_data   = 16'h5A5A;
                inject_rsp = 1'b0;
            end
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    rsp_valid = 1'b1;
                    if (nack_next) begin
                        rsp_nack  = 1'b1;
                        nack_next = 1'b0;
                    end else if (pend_kind == 2'd2) begin
                        if (pend_reg == 8'h01) begin
                            rsp_data = 16'h8000;
                            if (os_q.size() > 0) rsp_data = os_q.pop_front();
                        end else begin
                            rsp_data = 16'hDEAD;
                            if (conv_q.size() > 0) rsp_data = conv_q.pop_front();
                            sample_due = 1'b1;
                        end
                    end
                end
            end

            if (cmd_ready) begin
                cmd_ready = 1'b0;
            end else if (cmd_valid === 1'b1) begin
                if (hold_conv && cmd_kind == 2'd2 && cmd_reg == 8'h00) begin
                    cmd_ready = 1'b0;
                end else if (stall_left > 0) begin
                    if (!stall_cap) begin
                        cap       = {cmd_addr, cmd_kind, cmd_reg, cmd_data};
                        stall_cap = 1'b1;
                    end else begin
                        stall_cmp++;
                        check("stall_stable", 64'({cmd_addr, cmd_kind, cmd_reg, cmd_data}), 64'(cap));
                    end
                    stall_left--;
                end else begin
                    if (stall_cap) begin
                        stall_cmp++;
                        check("stall_stable", 64'({cmd_addr, cmd_kind, cmd_reg, cmd_data}), 64'(cap));
                        stall_cap = 1'b0;
                    end
                    cmd_ready = 1'b1;
                    n_desc++;
                    if (chk_desc) begin
                        ed = (exp_desc.size() > 0) ? exp_desc.pop_front() : 26'h3FFFFFF;
                        check("desc", 64'({cmd_kind, cmd_reg, cmd_data}), 64'(ed));
                        check("desc_addr", 64'(cmd_addr), 64'h48);
                    end
                    if (cmd_kind == 2'd2 && cmd_reg == 8'h01) n_cfg_reads++;
                    pend_kind = cmd_kind;
                    pend_reg  = cmd_reg;
                    rsp_wait  = 2;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        int base;
        int dbase;
        bit found;

        step(3);
        check("rst_cmd_valid",    64'(cmd_valid),    64'd0);
        check("rst_cmd_kind",     64'(cmd_kind),     64'd0);
        check("rst_cmd_addr",     64'(cmd_addr),     64'h48);
        check("rst_cmd_reg",      64'(cmd_reg),      64'd0);
        check("rst_cmd_data",     64'(cmd_data),     64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_sample_ch",    64'(sample_ch),    64'd0);
        check("rst_sample_data",  64'(sample_data),  64'd0);
        check("rst_busy",         64'(busy),         64'd0);
        check("rst_err_nack",     64'(err_nack),     64'd0);
        check("rst_err_timeout",  64'(err_timeout),  64'd0);
        rst_n = 1'b1;
        step(2);

        // Full single scan of all channels, descriptors checked in order
        chk_desc = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            push_channel_descs(ch);
            push_sample(ch, 16'h1000 + 16'(ch * 273));
        end
        base   = n_samples;
        enable = 1'b1;
        wait_busy(1'b1, 20, "scan_start");
        wait_busy(1'b0, 2000, "scan_done");
        enable = 1'b0;
        check("scan_samples",    64'(n_samples - base),  64'd4);
        check("scan_desc_left",  64'(exp_desc.size()),   64'd0);
        check("scan_samp_left",  64'(exp_samp.size()),   64'd0);
        chk_desc = 1'b0;

        // OS polling: two busy reads then ready
        step(2);
        n_cfg_reads = 0;
        base = n_samples;
        os_q.push_back(16'h4383);
        os_q.push_back(16'h4383);
        os_q.push_back(16'hC383);
        push_sample(0, 16'h1234);
        enable = 1'b1;
        wait_busy(1'b1, 20, "poll_start");
        enable = 1'b0;
        wait_busy(1'b0, 1000, "poll_done");
        check("poll_reads",       64'(n_cfg_reads),       64'd3);
        check("poll_samples",     64'(n_samples - base),  64'd1);
        check("poll_sample_data", 64'(sample_data),       64'h1234);
        check("poll_no_timeout",  64'(err_timeout),       64'd0);

        // Timeout: OS never set within POLL_MAX polls
        step(2);
        n_cfg_reads = 0;
        base = n_samples;
        repeat (4) os_q.push_back(16'h0383);
        enable = 1'b1;
        wait_busy(1'b1, 20, "tmo_start");
        enable = 1'b0;
        wait_busy(1'b0, 1000, "tmo_done");
        check("tmo_err_timeout", 64'(err_timeout),      64'd1);
        check("tmo_reads",       64'(n_cfg_reads),      64'd4);
        check("tmo_no_sample",   64'(n_samples - base), 64'd0);
        check("tmo_err_nack",    64'(err_nack),         64'd0);

        // NACK on the config write
        step(2);
        dbase     = n_desc;
        base      = n_samples;
        nack_next = 1'b1;
        enable    = 1'b1;
        wait_busy(1'b1, 20, "nack_start");
        check("nack_clears_timeout", 64'(err_timeout), 64'd0);
        enable = 1'b0;
        wait_busy(1'b0, 200, "nack_done");
        check("nack_err",       64'(err_nack),          64'd1);
        check("nack_desc_cnt",  64'(n_desc - dbase),    64'd1);
        check("nack_no_sample", 64'(n_samples - base),  64'd0);

        // Restart after NACK clears the flag and begins at ch0
        step(2);
        chk_desc = 1'b1;
        push_channel_descs(0);
        push_sample(0, 16'hBEEF);
        enable = 1'b1;
        wait_busy(1'b1, 20, "restart_start");
        check("restart_clears_nack", 64'(err_nack), 64'd0);
        enable = 1'b0;
        wait_busy(1'b0, 1000, "restart_done");
        check("restart_desc_left", 64'(exp_desc.size()), 64'd0);
        check("restart_samp_left", 64'(exp_samp.size()), 64'd0);
        chk_desc = 1'b0;

        // Continuous wrap with a stalled first descriptor, enable dropped during ch1
        step(2);
        base       = n_samples;
        stall_cmp  = 0;
        continuous = 1'b1;
        push_sample(0, 16'h2000);
        push_sample(1, 16'h2001);
        push_sample(2, 16'h2002);
        push_sample(3, 16'h2003);
        push_sample(0, 16'h2004);
        push_sample(1, 16'h2005);
        stall_left = 5;
        enable     = 1'b1;
        wait_samples(base + 5, 3000, "cont_wrap");
        enable = 1'b0;
        wait_busy(1'b0, 1000, "cont_done");
        continuous = 1'b0;
        check("cont_samples",   64'(n_samples - base), 64'd6);
        check("cont_samp_left", 64'(exp_samp.size()),  64'd0);
        check("cont_stall_cmp", 64'(stall_cmp),        64'd5);

        // Asynchronous reset while RD_CONV descriptor is pending
        step(2);
        hold_conv = 1'b1;
        enable    = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (cmd_valid === 1'b1 && cmd_kind == 2'd2 && cmd_reg == 8'h00) found = 1'b1;
            else step(1);
        end
        check("arst_reached_rd_conv", 64'(found), 64'd1);
        base = n_samples;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_valid",    64'(cmd_valid),    64'd0);
        check("arst_cmd_kind",     64'(cmd_kind),     64'd0);
        check("arst_cmd_addr",     64'(cmd_addr),     64'h48);
        check("arst_cmd_reg",      64'(cmd_reg),      64'd0);
        check("arst_cmd_data",     64'(cmd_data),     64'd0);
        check("arst_sample_valid", 64'(sample_valid), 64'd0);
        check("arst_sample_ch",    64'(sample_ch),    64'd0);
        check("arst_sample_data",  64'(sample_data),  64'd0);
        check("arst_busy",         64'(busy),         64'd0);
        check("arst_err_nack",     64'(err_nack),     64'd0);
        check("arst_err_timeout",  64'(err_timeout),  64'd0);
        enable    = 1'b0;
        hold_conv = 1'b0;
        step(2);
        rst_n      = 1'b1;
        inject_rsp = 1'b1;
        step(6);
        check("arst_late_rsp_no_sample", 64'(n_samples - base), 64'd0);
        check("arst_idle_busy",          64'(busy),             64'd0);
        check("arst_idle_cmd_valid",     64'(cmd_valid),        64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
